vga_color_fader: RTL
====================

Name: vga_color_fader

Overview:
- Frame-synchronous colour sequencer for the VGA pixel datapath.
- Drives the R/G/B values fed to the DAC: on `start` it fades linearly from a start colour to an end colour over 2^FADE_LOG2 frames, holds the end colour, then finishes.
- Updates occur only on the timing generator's frame-end pulse, so a frame never shows a mid-frame colour change.
- Sits between the VGA timing block and the VGA_R/G/B outputs of the top level.

Parameters:
- FADE_LOG2, 6, log2 of fade length in frames (fade = 64 frames).
- HOLD_FRAMES, 32, frames the end colour is held before completion (1..255).
- RESET_COLOR, 24'h37C897, {R,G,B} driven out of reset and in IDLE before the first fade.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous active-high reset
- frame_end  in  1  one-cycle pulse from the timing block at the end of each frame
- start  in  1  one-cycle request to begin a fade; accepted only in IDLE
- stop  in  1  abort; returns to IDLE, colour frozen at its current value
- start_color  in  24  {R[23:16],G[15:8],B[7:0]}, sampled on an accepted start
- end_color  in  24  same packing, sampled on an accepted start
- color_r  out  8  red to DAC
- color_g  out  8  green to DAC
- color_b  out  8  blue to DAC
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a sequence completes

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous, active-high.
- Reset values: state=IDLE, color_*=RESET_COLOR fields, busy=0, done=0, frame counter k=0, hold counter=0, latched colours=0.
- State machine: IDLE, FADE, HOLD (plus REV when the optional feature is enabled).
- IDLE:
  - On start, latch start_color/end_color, set k=0, go to FADE.
  - color_* = start_color on the next cycle (registered, 1-cycle latency).
  - A frame_end in the same cycle as start does not advance k.
- FADE:
  - Each frame_end increments k.
  - The cycle after a frame_end, each channel = S + ((E - S) * k) >>> FADE_LOG2.
  - E - S is a signed 9-bit value; the product is signed 9+FADE_LOG2+1 bits; >>> is an arithmetic (floor) shift.
  - The result is always within [min(S,E), max(S,E)] and never wraps.
  - When k reaches 2^FADE_LOG2, the output equals E exactly; go to HOLD with hold counter=0.
- HOLD:
  - Output = E. Each frame_end increments the hold counter.
  - On reaching HOLD_FRAMES, pulse done for 1 cycle and go to IDLE with the output left at E.
- Handshake:
  - start while busy is ignored; no queueing.
  - start and stop in the same cycle: stop wins; start is dropped.
- stop: in any non-IDLE state, go to IDLE next cycle. Colour keeps its last value, done is not pulsed, busy drops.
- frame_end outside FADE/HOLD/REV has no effect.
- S == E: fade still runs 2^FADE_LOG2 frames with constant output; done timing is unchanged.
- Reset mid-sequence restores reset values immediately at the next clock edge; latched colours are discarded.
- Only frame_end advances state (besides start/stop/rst). Outputs change only on the cycle after frame_end, start or stop, never otherwise.

Optional Feature:
- Macro: VGA_FADE_PINGPONG_EN.
- Defined:
  - HOLD completion goes to REV instead of IDLE. done pulses at that transition and busy stays high.
  - REV decrements k on each frame_end using the same formula. At k=0 (output = S exactly), go back to FADE.
  - The loop runs until stop or rst.
- Not defined:
  - REV state and logic are absent; HOLD completion always goes to IDLE.

Test Plan:
- Reset then idle 3 frames -> color = 37/C8/97, busy=0, done=0 throughout.
- start with S=000000, E=FF8040, FADE_LOG2=6:
  - cycle after start, color=00/00/00.
  - after frame 32, color=7F/40/20.
  - after frame 64, color=FF/80/40 and the state is HOLD.
- Descending fade S=FF0000, E=000000:
  - after frame 1, R = 255 + floor(-255/64) = 251 (FB).
  - after frame 64, R = 00; no wrap at any step.
- Full sequence with HOLD_FRAMES=32 -> done pulses exactly once, 1 cycle after the 96th frame_end; busy falls the same cycle; color stays at E.
- Fade 10 frames in, then:
  - start -> ignored.
  - stop -> IDLE next cycle, color frozen at its frame-10 value, no done pulse.
  - start+stop together -> stop wins, start dropped.
- With VGA_FADE_PINGPONG_EN, S=000000, E=FFFFFF:
  - after 64+32+64 frames, output = 00/00/00, state = FADE, done has pulsed once.
  - rst then restores 37/C8/97.

Source files
------------

// File: rtl/vga_color_fader_if.sv
// ---------------------------------------------------------------------------
// vga_color_fader_if
//   Bundles the frame timing, control and colour signals of vga_color_fader.
//
//   Handshake: start and stop are single-cycle, level-sampled requests.
//   They have no ready/acknowledge. start is taken only when the fader is
//   idle (busy low) and stop is low in the same cycle. stop always takes
//   priority. done is a one-cycle completion pulse. busy is high whenever a
//   sequence is in progress.
//
//   Modports:
//     master : drives frame_end/start/stop/start_color/end_color and
//              observes colour/busy/done/state_dbg
//     slave  : the fader itself
//   Signals:
//     frame_end   - one-cycle end-of-frame pulse from the timing block
//     start, stop - control requests
//     start_color, end_color - {R,G,B} packed, 8 bits each
//     color_r/g/b - channel values to the DAC
//     busy, done  - status outputs
//     state_dbg   - current FSM state encoding (IDLE=0 FADE=1 HOLD=2 REV=3)
// ---------------------------------------------------------------------------
interface vga_color_fader_if;
  logic        frame_end;
  logic        start;
  logic        stop;
  logic [23:0] start_color;
  logic [23:0] end_color;
  logic [7:0]  color_r;
  logic [7:0]  color_g;
  logic [7:0]  color_b;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  modport master (
    output frame_end, start, stop, start_color, end_color,
    input  color_r, color_g, color_b, busy, done, state_dbg
  );

  modport slave (
    input  frame_end, start, stop, start_color, end_color,
    output color_r, color_g, color_b, busy, done, state_dbg
  );
endinterface

// File: rtl/vga_color_fader.sv
// ---------------------------------------------------------------------------
// vga_color_fader
//   Frame-synchronous colour sequencer. On start it fades linearly from a
//   start colour to an end colour over 2^FADE_LOG2 frames, holds the end
//   colour for HOLD_FRAMES frames, pulses done and returns to idle. All
//   colour updates happen on the cycle after frame_end (or after start/stop),
//   so a visible frame never contains a colour change.
//
//   Optional feature macro: VGA_FADE_PINGPONG_EN
//     When defined, completion of HOLD enters REV, which fades back to the
//     start colour and then loops into FADE again until stop or rst.
//
//   Ports:
//     clk  - system clock
//     rst  - synchronous active-high reset
//     bus  - vga_color_fader_if.slave (control, colours, status, state_dbg)
// ---------------------------------------------------------------------------
module vga_color_fader #(
  parameter int          FADE_LOG2   = 6,
  parameter int          HOLD_FRAMES = 32,
  parameter logic [23:0] RESET_COLOR = 24'h37C897
) (
  input  logic             clk,
  input  logic             rst,
  vga_color_fader_if.slave bus
);

  // k runs 0..2^FADE_LOG2 inclusive, so it needs one bit beyond FADE_LOG2.
  localparam int            KW        = FADE_LOG2 + 1;
  localparam logic [KW-1:0] K_MAX     = KW'(1) << FADE_LOG2;
  localparam logic [7:0]    HOLD_LAST = 8'(HOLD_FRAMES);

`ifdef VGA_FADE_PINGPONG_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FADE = 2'd1, ST_HOLD = 2'd2, ST_REV = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FADE = 2'd1, ST_HOLD = 2'd2} state_t;
`endif

  state_t        state, state_next;
  logic [KW-1:0] k;
  logic [7:0]    hold_cnt;
  logic [23:0]   s_lat, e_lat;
  logic [23:0]   color;
  logic          done_q;

  logic          accept_start, fade_step, hold_step;
  logic [KW-1:0] k_inc;
  logic [7:0]    hold_inc;
`ifdef VGA_FADE_PINGPONG_EN
  logic          rev_step;
  logic [KW-1:0] k_dec;
`endif

  assign k_inc    = k + KW'(1);
  assign hold_inc = hold_cnt + 8'd1;
`ifdef VGA_FADE_PINGPONG_EN
  assign k_dec    = k - KW'(1);
`endif

  // One channel: s + floor((e - s) * kk / 2^FADE_LOG2). The difference is
  // signed so descending fades floor toward e and never wrap; the result
  // always lies between s and e, so the low 8 bits of the sum are exact.
  function automatic logic [7:0] blend(input logic [7:0] s, input logic [7:0] e,
                                       input logic [KW-1:0] kk);
    logic signed [8:0]    diff;
    logic signed [KW+9:0] prod;
    logic signed [KW+9:0] shifted;
    logic signed [9:0]    sum;
    diff    = $signed({1'b0, e}) - $signed({1'b0, s});
    prod    = (KW+10)'(diff) * (KW+10)'($signed({1'b0, kk}));
    shifted = prod >>> FADE_LOG2;
    sum     = $signed({2'b00, s}) + $signed(shifted[9:0]);
    return sum[7:0];
  endfunction

  function automatic logic [23:0] blend_rgb(input logic [23:0] s, input logic [23:0] e,
                                            input logic [KW-1:0] kk);
    return {blend(s[23:16], e[23:16], kk), blend(s[15:8], e[15:8], kk),
            blend(s[7:0], e[7:0], kk)};
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; also decodes the datapath step strobes.
  always_comb begin
    state_next   = state;
    accept_start = 1'b0;
    fade_step    = 1'b0;
    hold_step    = 1'b0;
`ifdef VGA_FADE_PINGPONG_EN
    rev_step     = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        // stop in the same cycle drops the start request
        if (bus.start && !bus.stop) begin
          accept_start = 1'b1;
          state_next   = ST_FADE;
        end
      end
      ST_FADE: begin
        if (bus.stop) state_next = ST_IDLE;
        else if (bus.frame_end) begin
          fade_step = 1'b1;
          if (k_inc == K_MAX) state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.stop) state_next = ST_IDLE;
        else if (bus.frame_end) begin
          hold_step = 1'b1;
`ifdef VGA_FADE_PINGPONG_EN
          if (hold_inc == HOLD_LAST) state_next = ST_REV;
`else
          if (hold_inc == HOLD_LAST) state_next = ST_IDLE;
`endif
        end
      end
`ifdef VGA_FADE_PINGPONG_EN
      ST_REV: begin
        if (bus.stop) state_next = ST_IDLE;
        else if (bus.frame_end) begin
          rev_step = 1'b1;
          if (k_dec == '0) state_next = ST_FADE;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy      = (state != ST_IDLE);
    bus.state_dbg = state;
    bus.done      = done_q;
    bus.color_r   = color[23:16];
    bus.color_g   = color[15:8];
    bus.color_b   = color[7:0];
  end

  // Datapath: counters, latched colours and the registered output colour.
  // stop needs no action here: the colour simply keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      k        <= '0;
      hold_cnt <= '0;
      s_lat    <= '0;
      e_lat    <= '0;
      color    <= RESET_COLOR;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept_start) begin
        s_lat <= bus.start_color;
        e_lat <= bus.end_color;
        k     <= '0;
        color <= bus.start_color;
      end
      if (fade_step) begin
        k     <= k_inc;
        color <= blend_rgb(s_lat, e_lat, k_inc);
        if (k_inc == K_MAX) hold_cnt <= '0;
      end
      if (hold_step) begin
        if (hold_inc == HOLD_LAST) begin
          done_q   <= 1'b1;
          hold_cnt <= '0;
        end else begin
          hold_cnt <= hold_inc;
        end
      end
`ifdef VGA_FADE_PINGPONG_EN
      if (rev_step) begin
        k     <= k_dec;
        color <= blend_rgb(s_lat, e_lat, k_dec);
      end
`endif
    end
  end

endmodule
